// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory:
// access size codes, FSM state codes and the INIT contents table.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  function automatic logic [31:0] INIT_WORD(
    input int idx
  );
    case (idx)
      0:       INIT_WORD = 32'd250;
      1:       INIT_WORD = 32'd200;
      2:       INIT_WORD = 32'd20;
      3:       INIT_WORD = 32'd10;
      4:       INIT_WORD = 32'd300;
      5:       INIT_WORD = 32'd450;
      default: INIT_WORD = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_bw_load_align.sv
// Load lane select and sign/zero extension.
// Ports: word, size, offset (byte addr [1:0]), unsigned_ld -> result.
module load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        bs;
  logic        hs;

  always_comb begin
    b  = word[{offset, 3'b000} +: 8];
    h  = word[{offset[1], 4'b0000} +: 16];
    bs = ~unsigned_ld & b[7];
    hs = ~unsigned_ld & h[15];
    unique case (1'b1)
      (size == SZ_B): result = {{(DATA_W-8){bs}}, b};
      (size == SZ_H): result = {{(DATA_W-16){hs}}, h};
      default:        result = word;
    endcase
  end

endmodule

// File: rtl/data_memory_bw.sv
// Word-organised RAM with byte/half/word access, registered loads
// and a power-up INIT walk. Ports: clock, reset, memread, memwrite,
// size, unsigned_ld, inadd, wdata -> outdata, rvalid, ready,
// misalign, m (word 6 debug tap).
module data_memory_bw
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] inadd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] outdata,
  output logic              rvalid,
  output logic              ready,
  output logic              misalign,
  output logic [DATA_W-1:0] m
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [IW-1:0]     cnt;

  logic [IW-1:0]     idx;
  logic [1:0]        off;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;
  logic              mis;
  logic              ld;
  logic              st;

  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic              unused_addr;

  assign unused_addr = ^inadd[ADDR_W-1:IW+2];

  assign ready = (state == ST_IDLE);
  assign idx   = inadd[IW+1:2];
  assign off   = inadd[1:0];
  assign cur   = mem[idx];

  assign mis = ((size == SZ_H) & off[0]) |
               (size[1] & (off != 2'b00));

  assign st = ready & memwrite;
  assign ld = ready & memread & ~memwrite;

  // Word 6 is hidden until the INIT walk has passed it, so a
  // restarted INIT never exposes stale contents.
  assign m = (ready | (cnt > IW'(6))) ? mem[6] : '0;

  load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .word       (cur),
    .size       (size),
    .offset     (off),
    .unsigned_ld(unsigned_ld),
    .result     (ld_data)
  );

  // Read-modify-write merge of the selected lanes.
  always_comb begin
    st_word = cur;
    unique case (1'b1)
      (size == SZ_B):
        st_word[{off, 3'b000} +: 8] = wdata[7:0];
      (size == SZ_H):
        st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default:
        st_word = wdata;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = st_word;
    if (!reset) begin
      if (!ready) begin
        wr_en   = 1'b1;
        wr_idx  = cnt;
        wr_data = DATA_W'(INIT_WORD(int'(cnt)));
      end else if (st && !mis) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      cnt      <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      outdata  <= '0;
    end else begin
      rvalid   <= ld;
      misalign <= (ld | st) & mis;
      if (ld) outdata <= mis ? '0 : ld_data;
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IW'(DEPTH-1)) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bw.sv
// Self-checking bench for data_memory_bw: directed table,
// INIT/reset sequences and randomized ops against a reference model.
module tb_data_memory_bw;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        unsigned_ld = 1'b0;
  logic [31:0] inadd = '0;
  logic [31:0] wdata = '0;
  logic [31:0] outdata;
  logic        rvalid;
  logic        ready;
  logic        misalign;
  logic [31:0] m;

  int vectors = 0;
  int miscompares = 0;

  data_memory_bw dut (
    .clock      (clock),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .inadd      (inadd),
    .wdata      (wdata),
    .outdata    (outdata),
    .rvalid     (rvalid),
    .ready      (ready),
    .misalign   (misalign),
    .m          (m)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          rv;
    bit          mis;
    logic [31:0] out;
    logic [31:0] m;
  } vec_t;

  vec_t tbl [20];

  // Reference memory: plain array of 32-bit words.
  logic [31:0] mm [32];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit rd, input bit wr,
                       input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
    memread = rd;
    memwrite = wr;
    size = sz;
    unsigned_ld = u;
    inadd = a;
    wdata = wd;
  endtask

  task automatic idle;
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
  endtask

  function automatic void model_reset;
    int vals [6] = '{250, 200, 20, 10, 300, 450};
    for (int i = 0; i < 32; i++) mm[i] = (i < 6) ? vals[i] : 0;
  endfunction

  function automatic bit model_mis(input logic [31:0] a,
                                   input int sz);
    return (sz == 1 && a % 2 != 0) || (sz >= 2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a,
                                             input int sz,
                                             input bit u);
    int unsigned w;
    int unsigned v;
    w = mm[(a / 4) % 32];
    if (sz == 0) begin
      v = (w >> ((a % 4) * 8)) % 256;
      if (!u && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (((a % 4) / 2) * 16)) % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a,
                                      input int sz,
                                      input logic [31:0] wd);
    int unsigned w;
    int unsigned sh;
    int i;
    if (model_mis(a, sz)) return;
    i = (a / 4) % 32;
    w = mm[i];
    if (sz == 0) begin
      sh = (a % 4) * 8;
      w = (w & ~(32'hFF << sh)) | ((wd % 256) << sh);
    end else if (sz == 1) begin
      sh = ((a % 4) / 2) * 16;
      w = (w & ~(32'hFFFF << sh)) | ((wd % 65536) << sh);
    end else begin
      w = wd;
    end
    mm[i] = w;
  endfunction

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (!ready && n < 100) begin
      if (n % 2 == 0) drive(1, 0, 2'b01, 0, 32'h1, 32'h0);
      else            drive(0, 1, 2'b10, 0, 32'h0, 32'hAAAA);
      tick();
      n++;
      check({nm, "_quiet"}, {rvalid, misalign}, 2'b00);
      if (n == 1) check({nm, "_m_init"}, m, 32'h0);
    end
    idle();
  endtask

  initial begin
    int n;
    logic [31:0] exp_out;
    model_reset();

    tbl[0]  = '{1, 0, 2'b10, 0, 32'h00, 32'h0, 1, 0, 32'd250, 32'h0};
    tbl[1]  = '{1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 0, 32'd200, 32'h0};
    tbl[2]  = '{1, 0, 2'b10, 0, 32'h08, 32'h0, 1, 0, 32'd20, 32'h0};
    tbl[3]  = '{1, 0, 2'b10, 0, 32'h14, 32'h0, 1, 0, 32'd450, 32'h0};
    tbl[4]  = '{1, 0, 2'b10, 0, 32'h18, 32'h0, 1, 0, 32'd0, 32'h0};
    tbl[5]  = '{0, 1, 2'b10, 0, 32'h18, 32'hDEADBEEF, 0, 0, 32'd0,
                32'hDEADBEEF};
    tbl[6]  = '{0, 1, 2'b00, 0, 32'h19, 32'h7F, 0, 0, 32'd0,
                32'hDEAD7FEF};
    tbl[7]  = '{1, 0, 2'b00, 0, 32'h1B, 32'h0, 1, 0, 32'hFFFFFFDE,
                32'hDEAD7FEF};
    tbl[8]  = '{1, 0, 2'b00, 1, 32'h1B, 32'h0, 1, 0, 32'h000000DE,
                32'hDEAD7FEF};
    tbl[9]  = '{1, 0, 2'b01, 0, 32'h1A, 32'h0, 1, 0, 32'hFFFFDEAD,
                32'hDEAD7FEF};
    tbl[10] = '{1, 0, 2'b01, 0, 32'h19, 32'h0, 1, 1, 32'h0,
                32'hDEAD7FEF};
    tbl[11] = '{0, 1, 2'b01, 0, 32'h19, 32'h1234, 0, 1, 32'h0,
                32'hDEAD7FEF};
    tbl[12] = '{0, 1, 2'b10, 0, 32'h00, 32'd5, 0, 0, 32'h0,
                32'hDEAD7FEF};
    tbl[13] = '{1, 0, 2'b10, 0, 32'h00, 32'h0, 1, 0, 32'd5,
                32'hDEAD7FEF};
    tbl[14] = '{0, 1, 2'b10, 0, 32'h80, 32'd7, 0, 0, 32'd5,
                32'hDEAD7FEF};
    tbl[15] = '{1, 0, 2'b10, 0, 32'h00, 32'h0, 1, 0, 32'd7,
                32'hDEAD7FEF};
    tbl[16] = '{1, 1, 2'b10, 0, 32'h04, 32'd9, 0, 0, 32'd7,
                32'hDEAD7FEF};
    tbl[17] = '{1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 0, 32'd9,
                32'hDEAD7FEF};
    tbl[18] = '{1, 0, 2'b10, 0, 32'h18, 32'h0, 1, 0, 32'hDEAD7FEF,
                32'hDEAD7FEF};
    tbl[19] = '{1, 0, 2'b11, 0, 32'h18, 32'h0, 1, 0, 32'hDEAD7FEF,
                32'hDEAD7FEF};

    // Reset state and INIT duration.
    reset = 1'b1;
    idle();
    tick();
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_outdata", outdata, 32'h0);
    reset = 1'b0;
    wait_ready("init", n);
    check("init_cycles", n, 32);

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].u,
            tbl[i].addr, tbl[i].wd);
      tick();
      check($sformatf("tbl%0d_rvalid", i), {31'h0, rvalid},
            {31'h0, tbl[i].rv});
      check($sformatf("tbl%0d_mis", i), {31'h0, misalign},
            {31'h0, tbl[i].mis});
      check($sformatf("tbl%0d_out", i), outdata, tbl[i].out);
      check($sformatf("tbl%0d_m", i), m, tbl[i].m);
    end
    idle();
    tick();
    check("rvalid_pulse", {31'h0, rvalid}, 32'h0);
    check("out_hold", outdata, 32'hDEAD7FEF);

    // Reset at cnt = 10 restarts the INIT walk.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 2'b10, 0, 32'h0, 32'h55);
      tick();
      check("mid_quiet", {rvalid, misalign}, 2'b00);
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("reinit", n);
    check("reinit_cycles", n, 32);
    model_reset();
    drive(1, 0, 2'b10, 0, 32'h0, 32'h0);
    tick();
    check("reinit_ld0", outdata, 32'd250);
    check("reinit_m", m, 32'h0);

    // Randomized ops against the reference model.
    exp_out = outdata;
    for (int i = 0; i < 400; i++) begin
      bit rd;
      bit wr;
      bit u;
      int sz;
      logic [31:0] a;
      logic [31:0] wd;
      bit ms;
      rd = ($urandom % 3) != 0;
      wr = ($urandom % 3) == 0;
      u  = $urandom % 2;
      sz = $urandom % 4;
      a  = $urandom % 256;
      wd = $urandom;
      ms = model_mis(a, sz);
      if (rd && !wr) exp_out = ms ? 32'h0 : model_load(a, sz, u);
      if (wr) model_store(a, sz, wd);
      drive(rd, wr, 2'(sz), u, a, wd);
      tick();
      check("rnd_rvalid", {31'h0, rvalid}, {31'h0, rd && !wr});
      check("rnd_mis", {31'h0, misalign},
            {31'h0, (rd || wr) && ms});
      check("rnd_out", outdata, exp_out);
      check("rnd_m", m, mm[6]);
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_bw.md
# data_memory_bw

Parametrised successor to the single-cycle data memory: a word-organised RAM that supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads are registered and return one cycle after the request. On reset, the block re-initialises its contents one word per cycle and signals readiness afterwards. It sits between the ALU address output and the write-back mux of the processor datapath.

## Interface
- DATA_W, 32: data width; must be a multiple of 8.
- DEPTH, 32: number of words; must be a power of 2, at least 8.
- ADDR_W, 32: width of the byte address.
- clock  in  1  single clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high; starts the INIT sequence.
- memread  in  1  load request.
- memwrite  in  1  store request.
- size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- unsigned_ld  in  1  1 = zero-extend a load; 0 = sign-extend.
- inadd  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-aligned.
- outdata  out  DATA_W  load result.
- rvalid  out  1  one-cycle pulse marking a load result.
- ready  out  1  block accepts requests.
- misalign  out  1  one-cycle pulse marking a misaligned access.
- m  out  DATA_W  debug tap: word 6.

## Operation
- Word index: inadd[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap.
- Byte lanes are little-endian: byte k of a word is bits [8k+7:8k].
- FSM states:
  - INIT: cnt writes INIT_WORD(cnt) to mem[cnt] each cycle. When cnt == DEPTH-1 the FSM goes to IDLE. ready = 0.
  - IDLE: ready = 1 and requests are serviced.
  - No other states.
- Reset, from any state: state = INIT, cnt = 0, ready = 0, rvalid = 0, misalign = 0, outdata = 0. Reset mid-INIT restarts the count from 0.
- Requests while ready = 0 are ignored: no write, no rvalid, no misalign.
- Store, memwrite = 1:
  - Only the selected lanes are written; other lanes keep their value.
  - Halfword lane pair is chosen by inadd[1]; byte lane by inadd[1:0].
- Load, memread = 1, memwrite = 0:
  - Next cycle: rvalid = 1 and outdata = the selected lanes, extended per unsigned_ld.
  - outdata holds its value until the next load result or reset.
- memread and memwrite both set: the access is a store only; no rvalid.
- Misaligned access (halfword with inadd[0] = 1, or word with inadd[1:0] ≠ 00):
  - No write occurs.
  - Next cycle: misalign = 1 for one cycle.
  - If the access was a load, rvalid = 1 and outdata = 0.
- m reflects mem[6] combinationally. It reads 0 during INIT until word 6 is written.

## Timing
- Store commits at the edge that samples it.
- Load latency is 1 cycle: request in cycle N, rvalid/outdata in cycle N+1.
- Read-after-write: a load in cycle N+1 to the address stored in cycle N returns the new data.
- Back-to-back loads return one result per cycle.
- After reset deasserts, ready rises exactly DEPTH cycles later, e.g. 32 cycles for the default.

## Structure
- Shared package `dmem_pkg`:
  - size encoding constants SZ_B, SZ_H, SZ_W.
  - function INIT_WORD(idx), returning 250, 200, 20, 10, 300, 450 for indices 0–5 and 0 elsewhere.
- Sub-module `load_align`: combinational lane select plus sign/zero extension (word, size, offset, unsigned_ld → DATA_W result). Shared with future cache fill logic.
- Storage is an inferred register array. No reset port on the array itself; it is cleared only by the INIT walk.

## Test plan
- Reset held 1 cycle, then released: ready = 0 for 32 cycles, then 1. Word loads at 0x0, 0x4, 0x8, 0x14 return 250, 200, 20, 450. Word load at 0x18 returns 0.
- Store word 0xDEADBEEF at 0x18, then store byte 0x7F at 0x19: m = 0xDEAD7FEF. Load byte signed at 0x1B returns 0xFFFFFFDE; unsigned returns 0x000000DE.
- Halfword load signed at 0x1A returns 0xFFFFDEAD. Halfword load at 0x19 gives misalign = 1, rvalid = 1, outdata = 0. Halfword store at 0x19 leaves memory unchanged.
- Store word 5 at 0x0 in cycle N, load 0x0 in cycle N+1: outdata = 5 in cycle N+2. Store word 7 at 0x80 (wraps to index 0): load 0x0 returns 7.
- Assert reset for 1 cycle at cnt = 10 during INIT: ready rises 32 cycles after release, not 22. Load 0x0 returns 250. Loads and stores issued during INIT have no effect.
- memread and memwrite both 1, storing 9 at 0x4: no rvalid; a later load of 0x4 returns 9.
